pipelined_addsub: RTL and testbench

- Parametrised, pipelined W-bit adder/subtractor. It is the next generation of the registered adder used in the ALU datapath.
- The carry chain is split into STAGES equal slices, with one slice resolved per clock stage.
- Adds a valid/ready handshake with backpressure, an add/sub mode, and registered status flags (carry, signed overflow, zero).
- Sits between the operand muxes and the ALU result register. The multicycle controller issues one operation per accepted handshake.

---
 rtl/pipelined_addsub_if.sv | 28 ++
 rtl/pipelined_addsub.sv | 99 +++++++++
 tb/tb_pipelined_addsub.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_addsub_if.sv
// Operand/result bundle for the pipelined adder/subtractor: request side
// (in_valid/in_ready + operands) and result side (out_valid/out_ready + sum, flags).
interface pipelined_addsub_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    logic         zero;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf, zero
    );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined W-bit add/sub: one CW-bit carry slice resolved per stage, flags registered with the sum.
// Latency: STAGES cycles from acceptance to out_valid; the last stage is the output register.
// Backpressure: one global enable freezes every stage while the result is held; in_ready = out_ready || !out_valid.
module pipelined_addsub #(
    parameter int W      = 32,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    pipelined_addsub_if.slave bus
);
    localparam int CW = W / STAGES;
    localparam int NP = (STAGES > 1) ? STAGES - 1 : 1;

    // Operands travel with the partial result so each stage only touches its own slice.
    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] bb;
        logic [W-1:0] r;
        logic         cy;
    } stage_t;

    logic         en;
    stage_t       in_st;
    stage_t       pipe_q     [NP];
    logic         pipe_vld_q [NP];
    stage_t       st_src     [STAGES];
    stage_t       st_res     [STAGES];
    logic         src_vld    [STAGES];

    logic [W-1:0] sum_q;
    logic         c_out_q;
    logic         ovf_q;
    logic         zero_q;
    logic         out_vld_q;
    logic         ovf_d;

    assign en            = bus.out_ready || !out_vld_q;
    assign bus.in_ready  = en;
    assign bus.out_valid = out_vld_q;
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

    always_comb begin
        in_st.a  = bus.a;
        in_st.bb = bus.sub ? ~bus.b : bus.b;
        in_st.r  = '0;
        in_st.cy = bus.c_in;
    end

    always_comb begin
        logic [CW:0] slice;
        slice      = '0;
        st_src[0]  = in_st;
        src_vld[0] = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            st_src[k]  = pipe_q[k-1];
            src_vld[k] = pipe_vld_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            slice = {1'b0, st_src[k].a[k*CW +: CW]}
                  + {1'b0, st_src[k].bb[k*CW +: CW]}
                  + {{CW{1'b0}}, st_src[k].cy};
            st_res[k]                = st_src[k];
            st_res[k].r[k*CW +: CW]  = slice[CW-1:0];
            st_res[k].cy             = slice[CW];
        end
    end

    // Sign bits of the conditioned operands are still carried unchanged into the last stage.
    assign ovf_d = (st_src[STAGES-1].a[W-1] == st_src[STAGES-1].bb[W-1])
                && (st_res[STAGES-1].r[W-1] != st_src[STAGES-1].a[W-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NP; k++) begin
                pipe_q[k]     <= '0;
                pipe_vld_q[k] <= 1'b0;
            end
            sum_q     <= '0;
            c_out_q   <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
            out_vld_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                pipe_q[k]     <= st_res[k];
                pipe_vld_q[k] <= src_vld[k];
            end
            sum_q     <= st_res[STAGES-1].r;
            c_out_q   <= st_res[STAGES-1].cy;
            ovf_q     <= ovf_d;
            zero_q    <= ~|st_res[STAGES-1].r;
            out_vld_q <= src_vld[STAGES-1];
        end
    end
endmodule

// File: tb/tb_pipelined_addsub.sv
// Drives three adder configurations (32/4, 32/1, 8/2) with shared directed stimulus and checks
// every handshake against an arithmetic scoreboard plus hand-computed literal results.
module tb_pipelined_addsub;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        c_in;
    logic        sub;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    bit          done;
    int          n_vec;
    int          n_err;

    typedef struct {
        logic [34:0] exp;
        int          acc;
        int          snap;
        bit          lit_on;
        logic [34:0] lit;
        int          lat;
    } ent_t;

    ent_t        scb     [3][$];
    bit          lit_on  [3];
    logic [34:0] lit_val [3];
    int          lit_lat [3];

    logic        ov [3];
    logic        ir [3];
    logic        co [3];
    logic        of [3];
    logic        zr [3];
    logic [31:0] sm [3];

    always #5 clk = ~clk;

    pipelined_addsub_if #(.W(32)) bus0 ();
    pipelined_addsub_if #(.W(32)) bus1 ();
    pipelined_addsub_if #(.W(8))  bus2 ();

    assign bus0.in_valid = in_valid;  assign bus1.in_valid = in_valid;  assign bus2.in_valid = in_valid;
    assign bus0.a = a;                assign bus1.a = a;                assign bus2.a = a[7:0];
    assign bus0.b = b;                assign bus1.b = b;                assign bus2.b = b[7:0];
    assign bus0.c_in = c_in;          assign bus1.c_in = c_in;          assign bus2.c_in = c_in;
    assign bus0.sub = sub;            assign bus1.sub = sub;            assign bus2.sub = sub;
    assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready; assign bus2.out_ready = out_ready;

    assign ov[0] = bus0.out_valid; assign ov[1] = bus1.out_valid; assign ov[2] = bus2.out_valid;
    assign ir[0] = bus0.in_ready;  assign ir[1] = bus1.in_ready;  assign ir[2] = bus2.in_ready;
    assign co[0] = bus0.c_out;     assign co[1] = bus1.c_out;     assign co[2] = bus2.c_out;
    assign of[0] = bus0.ovf;       assign of[1] = bus1.ovf;       assign of[2] = bus2.ovf;
    assign zr[0] = bus0.zero;      assign zr[1] = bus1.zero;      assign zr[2] = bus2.zero;
    assign sm[0] = bus0.sum;       assign sm[1] = bus1.sum;       assign sm[2] = {24'd0, bus2.sum};

    pipelined_addsub #(.W(32), .STAGES(4)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    pipelined_addsub #(.W(32), .STAGES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    pipelined_addsub #(.W(8),  .STAGES(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    function automatic int w_of(input int i);
        return (i == 2) ? 8 : 32;
    endfunction

    function automatic int st_of(input int i);
        case (i)
            0:       return 4;
            1:       return 1;
            default: return 2;
        endcase
    endfunction

    // Result packed as {c_out, ovf, zero, sum} computed with plain modulo-2^w arithmetic.
    function automatic logic [34:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic sb);
        logic [32:0] mask, xx, yy, full;
        logic [31:0] s;
        logic        c, v, z;
        mask = (33'd1 << w) - 33'd1;
        xx   = {1'b0, x} & mask;
        yy   = (sb ? ~{1'b0, y} : {1'b0, y}) & mask;
        full = xx + yy + {32'd0, ci};
        s    = full[31:0] & mask[31:0];
        c    = full[w];
        v    = (xx[w-1] == yy[w-1]) && (s[w-1] != xx[w-1]);
        z    = (s == 32'd0);
        return {c, v, z, s};
    endfunction

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, idx, act, req, $time);
        end
    endtask

    initial begin : compare
        ent_t        e;
        int          cyc;
        int          stalls   [3];
        bit          held_vld [3];
        logic [34:0] held     [3];
        logic [34:0] act;
        cyc = 0;
        for (int i = 0; i < 3; i++) begin
            stalls[i]   = 0;
            held_vld[i] = 1'b0;
            held[i]     = '0;
        end
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                #1;
                for (int i = 0; i < 3; i++) begin
                    chk("rst_out_valid", i, 64'(ov[i]), 64'd0);
                    chk("rst_outputs", i, 64'({co[i], of[i], zr[i], sm[i]}), 64'd0);
                    scb[i].delete();
                    held_vld[i] = 1'b0;
                end
            end else begin
                cyc++;
                if (done) begin
                    for (int i = 0; i < 3; i++) chk("drained", i, 64'(scb[i].size()), 64'd0);
                    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                    $finish;
                end
                for (int i = 0; i < 3; i++) begin
                    act = {co[i], of[i], zr[i], sm[i]};
                    chk("in_ready", i, 64'(ir[i]), 64'(out_ready || !ov[i]));
                    if (held_vld[i]) begin
                        chk("hold_valid", i, 64'(ov[i]), 64'd1);
                        chk("hold_data", i, 64'(act), 64'(held[i]));
                    end
                    if (ov[i] && out_ready) begin
                        if (scb[i].size() == 0) begin
                            chk("spurious_out", i, 64'(ov[i]), 64'd0);
                        end else begin
                            e = scb[i].pop_front();
                            chk("result", i, 64'(act), 64'(e.exp));
                            chk("latency", i, 64'(cyc - e.acc), 64'(st_of(i) + stalls[i] - e.snap));
                            if (e.lit_on) begin
                                chk("literal", i, 64'(act), 64'(e.lit));
                                chk("literal_lat", i, 64'(cyc - e.acc), 64'(e.lat));
                            end
                        end
                    end
                    held_vld[i] = ov[i] && !out_ready;
                    if (held_vld[i]) begin
                        held[i] = act;
                        stalls[i]++;
                    end
                    if (in_valid && ir[i]) begin
                        e.exp    = model(w_of(i), a, b, c_in, sub);
                        e.acc    = cyc;
                        e.snap   = stalls[i];
                        e.lit_on = lit_on[i];
                        e.lit    = lit_val[i];
                        e.lat    = lit_lat[i];
                        scb[i].push_back(e);
                    end
                end
            end
        end
    end

    task automatic set_lit(input int i, input logic [34:0] v, input int l);
        lit_on[i]  = 1'b1;
        lit_val[i] = v;
        lit_lat[i] = l;
    endtask

    task automatic clear_lit();
        for (int i = 0; i < 3; i++) lit_on[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds the operation until the 32/4 instance takes it; leaves in_valid high for streaming.
    task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic sb);
        bit acc;
        int g;
        a = x; b = y; c_in = ci; sub = sb; in_valid = 1'b1;
        g = 0;
        do begin
            @(negedge clk);
            acc = ir[0];
            @(posedge clk);
            #1;
            g++;
        end while (!acc && g < 20);
    endtask

    initial begin : stim
        int j;
        bit acc;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        idle(2);

        set_lit(0, {3'b000, 32'h0000_0003}, 4);
        drive(32'h1, 32'h2, 1'b0, 1'b0); clear_lit(); in_valid = 1'b0;
        idle(6);

        set_lit(0, {3'b101, 32'h0}, 4); set_lit(1, {3'b101, 32'h0}, 1); set_lit(2, {3'b101, 32'h0}, 2);
        drive(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0); clear_lit(); in_valid = 1'b0;
        idle(2);

        set_lit(0, {3'b110, 32'h7FFF_FFFF}, 4);
        drive(32'h8000_0000, 32'h1, 1'b1, 1'b1); clear_lit(); in_valid = 1'b0;
        idle(2);

        set_lit(0, {3'b000, 32'hFFFF_FFFE}, 4); set_lit(2, {3'b000, 32'h0000_00FE}, 2);
        drive(32'h5, 32'h7, 1'b1, 1'b1); clear_lit(); in_valid = 1'b0;
        idle(2);

        set_lit(0, {3'b010, 32'h8000_0000}, 4); set_lit(2, {3'b101, 32'h0}, 2);
        drive(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0); clear_lit(); in_valid = 1'b0;
        idle(6);

        for (int i = 0; i < 8; i++) drive(32'(i), 32'(i), 1'b0, 1'b0);
        in_valid = 1'b0;
        idle(8);

        // Output stall of three cycles in the middle of a six-operation stream.
        j = 0;
        for (int c = 0; c < 40 && j < 6; c++) begin
            a = 32'h100 + 32'(j) * 32'h0101_0101;
            b = 32'(j) * 32'd7;
            sub = j[0]; c_in = j[0]; in_valid = 1'b1;
            out_ready = !(c >= 5 && c < 8);
            @(negedge clk);
            acc = ir[0];
            @(posedge clk);
            #1;
            if (acc) j++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        idle(8);

        drive(32'd10, 32'd20, 1'b0, 1'b0);
        drive(32'd30, 32'd40, 1'b0, 1'b0);
        drive(32'd50, 32'd60, 1'b1, 1'b1);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        idle(1);

        set_lit(0, {3'b000, 32'h0000_2345}, 4);
        drive(32'h1234, 32'h1111, 1'b0, 1'b0); clear_lit(); in_valid = 1'b0;
        idle(10);
        done = 1'b1;
        idle(3);
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached with %0d vectors applied", n_vec);
        $fatal(1);
    end
endmodule
